// File: rtl/input_conditioner_if.sv
// Bundle of board-input pins, sticky-flag acknowledge and conditioned outputs
// shared by the IO decoder side (master) and the conditioner (slave).
interface input_conditioner_if #(
  parameter int NBTN = 2,
  parameter int NSW  = 16
);
  logic [NBTN-1:0] btn_raw;
  logic [NSW-1:0]  sw_raw;
  logic            ack_en;
  logic [NBTN-1:0] ack_mask;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_release;
  logic [NBTN-1:0] btn_sticky;
  logic [NSW-1:0]  sw_level;
  logic            sw_changed;

  modport master (
    output btn_raw, sw_raw, ack_en, ack_mask,
    input  btn_level, btn_press, btn_release, btn_sticky, sw_level, sw_changed
  );

  modport slave (
    input  btn_raw, sw_raw, ack_en, ack_mask,
    output btn_level, btn_press, btn_release, btn_sticky, sw_level, sw_changed
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces raw buttons/switches; buttons also get edge pulses
// and software-acknowledged sticky press flags for a polling CPU.
module input_conditioner #(
  parameter int NBTN      = 2,
  parameter int NSW       = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input_conditioner_if.slave io
);
  localparam int N  = NBTN + NSW;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 32'sd1);

  logic [N-1:0]          raw_s;
  logic [N-1:0]          flip_s;
  logic [N-1:0]          s1_d, s1_q;
  logic [N-1:0]          s2_d, s2_q;
  logic [N-1:0]          level_d, level_q;
  logic [N-1:0][CW-1:0]  cnt_d, cnt_q;
  logic [NBTN-1:0]       press_d, press_q;
  logic [NBTN-1:0]       release_d, release_q;
  logic [NBTN-1:0]       sticky_d, sticky_q;
  logic [NBTN-1:0]       clear_s;
  logic                  sw_changed_d, sw_changed_q;

  // Next-state: synchronizer shift, per-channel stable-count debounce, edge pulses, sticky flags
  always_comb begin
    raw_s   = {io.sw_raw, io.btn_raw};
    s1_d    = raw_s;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    flip_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = {CW{1'b0}};
        flip_s[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1'b1);
      end
    end
    // Pulses are registered alongside the level flip so they align with the new level
    press_d      = flip_s[NBTN-1:0] & s2_q[NBTN-1:0];
    release_d    = flip_s[NBTN-1:0] & ~s2_q[NBTN-1:0];
    sw_changed_d = |flip_s[N-1:NBTN];
    if (io.ack_en) begin
      clear_s = io.ack_mask;
    end else begin
      clear_s = {NBTN{1'b0}};
    end
    // A press landing on the same edge as an ack wins, so no press is lost
    sticky_d = (sticky_q & ~clear_s) | press_q;
  end

  // State registers with synchronous reset overriding all other updates
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= {N{1'b0}};
      s2_q         <= {N{1'b0}};
      level_q      <= {N{1'b0}};
      cnt_q        <= {(N*CW){1'b0}};
      press_q      <= {NBTN{1'b0}};
      release_q    <= {NBTN{1'b0}};
      sticky_q     <= {NBTN{1'b0}};
      sw_changed_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      release_q    <= release_d;
      sticky_q     <= sticky_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign io.btn_level   = level_q[NBTN-1:0];
  assign io.sw_level    = level_q[N-1:NBTN];
  assign io.btn_press   = press_q;
  assign io.btn_release = release_q;
  assign io.btn_sticky  = sticky_q;
  assign io.sw_changed  = sw_changed_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Table-driven bench: each row holds inputs for n cycles; the expected state and
// pulse counts for that row are queued at drive time and checked afterwards.
module tb_input_conditioner;
  localparam int NBTN = 2;
  localparam int NSW  = 16;
  localparam int DB   = 4;

  typedef struct {
    logic        rst;
    logic [1:0]  btn;
    logic [15:0] sw;
    logic        ack_en;
    logic [1:0]  ack_mask;
    int          n;
    logic [1:0]  lvl, prs, rel, stk;
    logic [15:0] swl;
    logic        chg;
    int          np, nr, nc;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cnt_p, cnt_r, cnt_c, overlap;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t e;

  input_conditioner_if #(.NBTN(NBTN), .NSW(NSW)) bus ();

  input_conditioner #(.NBTN(NBTN), .NSW(NSW), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic [1:0] btn, input logic [15:0] sw,
                             input logic ack_en, input logic [1:0] ack_mask, input int n,
                             input logic [1:0] lvl, input logic [1:0] prs, input logic [1:0] rel,
                             input logic [1:0] stk, input logic [15:0] swl, input logic chg,
                             input int np, input int nr, input int nc);
    vec_t r;
    r.rst = rst; r.btn = btn; r.sw = sw; r.ack_en = ack_en; r.ack_mask = ack_mask; r.n = n;
    r.lvl = lvl; r.prs = prs; r.rel = rel; r.stk = stk; r.swl = swl; r.chg = chg;
    r.np = np; r.nr = nr; r.nc = nc;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    // rst btn sw ack mask n | lvl prs rel stk sw_level chg | np nr nc
    vecs.push_back(v(1'b1, 2'b11, 16'hFFFF, 1'b0, 2'b00, 3,  2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b0, 2'b00, 5,  2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b0, 2'b00, 1,  2'b11, 2'b11, 2'b00, 2'b00, 16'hFFFF, 1'b1, 2, 0, 1));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b0, 2'b00, 1,  2'b11, 2'b00, 2'b00, 2'b11, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b1, 2'b01, 1,  2'b11, 2'b00, 2'b00, 2'b10, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b1, 2'b00, 1,  2'b11, 2'b00, 2'b00, 2'b10, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b1, 2'b10, 1,  2'b11, 2'b00, 2'b00, 2'b00, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b00, 16'hFFFF, 1'b0, 2'b00, 5,  2'b11, 2'b00, 2'b00, 2'b00, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b00, 16'hFFFF, 1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b11, 2'b00, 16'hFFFF, 1'b0, 0, 2, 0));
    vecs.push_back(v(1'b0, 2'b00, 16'hFFFF, 1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b00, 2'b00, 16'hFFFF, 1'b0, 0, 0, 0));
    // clean press on button 0, held 20 cycles in total
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 5,  2'b00, 2'b00, 2'b00, 2'b00, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b01, 2'b01, 2'b00, 2'b00, 16'hFFFF, 1'b0, 1, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 13, 2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    // glitches on button 1: 3 high, 1 low, 3 high
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b0, 2'b00, 3,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b0, 2'b00, 3,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 6,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    // 4-cycle pulse is accepted, then released
    vecs.push_back(v(1'b0, 2'b11, 16'hFFFF, 1'b0, 2'b00, 4,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b01, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b11, 2'b10, 2'b00, 2'b01, 16'hFFFF, 1'b0, 1, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b11, 2'b00, 2'b00, 2'b11, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 6,  2'b01, 2'b00, 2'b00, 2'b11, 16'hFFFF, 1'b0, 0, 1, 0));
    // sticky ack, then ack coinciding with a new press of button 0
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b1, 2'b01, 1,  2'b01, 2'b00, 2'b00, 2'b10, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b00, 16'hFFFF, 1'b0, 2'b00, 5,  2'b01, 2'b00, 2'b00, 2'b10, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b00, 16'hFFFF, 1'b0, 2'b00, 1,  2'b00, 2'b00, 2'b01, 2'b10, 16'hFFFF, 1'b0, 0, 1, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 5,  2'b00, 2'b00, 2'b00, 2'b10, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b01, 2'b01, 2'b00, 2'b10, 16'hFFFF, 1'b0, 1, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b1, 2'b01, 1,  2'b01, 2'b00, 2'b00, 2'b11, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b11, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hFFFF, 1'b1, 2'b11, 1,  2'b01, 2'b00, 2'b00, 2'b00, 16'hFFFF, 1'b0, 0, 0, 0));
    // switch bus: to 0000, then 0000 -> A5A5, then a 2-cycle glitch on bit 3
    vecs.push_back(v(1'b0, 2'b01, 16'h0000, 1'b0, 2'b00, 5,  2'b01, 2'b00, 2'b00, 2'b00, 16'hFFFF, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'h0000, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 0, 0, 1));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 5,  2'b01, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b00, 16'hA5A5, 1'b1, 0, 0, 1));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b00, 16'hA5A5, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5AD, 1'b0, 2'b00, 2,  2'b01, 2'b00, 2'b00, 2'b00, 16'hA5A5, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 6,  2'b01, 2'b00, 2'b00, 2'b00, 16'hA5A5, 1'b0, 0, 0, 0));
    // reset two cycles into a button 0 debounce
    vecs.push_back(v(1'b0, 2'b00, 16'hA5A5, 1'b0, 2'b00, 8,  2'b00, 2'b00, 2'b00, 2'b00, 16'hA5A5, 1'b0, 0, 1, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 2,  2'b00, 2'b00, 2'b00, 2'b00, 16'hA5A5, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b1, 2'b01, 16'hA5A5, 1'b1, 2'b11, 1,  2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 5,  2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 0, 0, 0));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 1,  2'b01, 2'b01, 2'b00, 2'b00, 16'hA5A5, 1'b1, 1, 0, 1));
    vecs.push_back(v(1'b0, 2'b01, 16'hA5A5, 1'b0, 2'b00, 1,  2'b01, 2'b00, 2'b00, 2'b01, 16'hA5A5, 1'b0, 0, 0, 0));

    n_cmp = 0;
    n_bad = 0;
    overlap = 0;
    reset = 1'b1;
    bus.btn_raw = 2'b00;
    bus.sw_raw = 16'h0000;
    bus.ack_en = 1'b0;
    bus.ack_mask = 2'b00;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      reset        = vecs[r].rst;
      bus.btn_raw  = vecs[r].btn;
      bus.sw_raw   = vecs[r].sw;
      bus.ack_en   = vecs[r].ack_en;
      bus.ack_mask = vecs[r].ack_mask;
      sb.push_back(vecs[r]);
      cnt_p = 0;
      cnt_r = 0;
      cnt_c = 0;
      for (int k = 0; k < vecs[r].n; k++) begin
        @(posedge clk);
        #1;
        cnt_p += $countones(bus.btn_press);
        cnt_r += $countones(bus.btn_release);
        cnt_c += $countones(bus.sw_changed);
        if ((bus.btn_press & bus.btn_release) != 2'b00) overlap++;
      end
      e = sb.pop_front();
      chk("btn_level",   r, 32'(bus.btn_level),   32'(e.lvl));
      chk("btn_press",   r, 32'(bus.btn_press),   32'(e.prs));
      chk("btn_release", r, 32'(bus.btn_release), 32'(e.rel));
      chk("btn_sticky",  r, 32'(bus.btn_sticky),  32'(e.stk));
      chk("sw_level",    r, 32'(bus.sw_level),    32'(e.swl));
      chk("sw_changed",  r, 32'(bus.sw_changed),  32'(e.chg));
      chk("press_pulses",   r, 32'(cnt_p), 32'(e.np));
      chk("release_pulses", r, 32'(cnt_r), 32'(e.nr));
      chk("change_pulses",  r, 32'(cnt_c), 32'(e.nc));
    end
    chk("press_release_overlap", vecs.size(), 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
